// File: rtl/pl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pl_pkg
// Purpose  : Shared definitions for the pipeline-register chain: the NOP
//            bubble word, the control bundle carried between the ID/EX and
//            EX/MEM stages, and the legal stage-count ceiling.
// Revision : 1.0 - initial release
// ============================================================================
package pl_pkg;

  // All-zero instruction word: sll $0,$0,0, used as the pipeline bubble.
  localparam logic [31:0] PL_NOP = 32'h0000_0000;

  // Largest chain depth an instance may be built with.
  localparam int unsigned PL_MAX_STAGES = 8;

  // Control bundle shared by the ID/EX and EX/MEM payloads.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch_eq_ne;
    logic [2:0] alu_op;
  } pl_ctrl_t;

  // Keeps an out-of-range depth from elaborating an empty or oversized chain.
  function automatic int unsigned pl_clamp_stages(input int unsigned stages);
    if (stages == 0) begin
      return 1;
    end
    if (stages > PL_MAX_STAGES) begin
      return PL_MAX_STAGES;
    end
    return stages;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pl_stage.sv
`default_nettype none
// ============================================================================
// Module   : pl_stage
// Purpose  : One register stage of the valid/ready pipeline chain: a main
//            entry, a flush that turns the stage into a bubble, and, when
//            PL_SKID_EN is defined, a skid entry with a registered ready.
// Config   : PL_SKID_EN - adds the skid entry and registers the ready.
// Revision : 1.0 - initial release
// ============================================================================
module pl_stage
  import pl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(PL_NOP)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  output logic                  ready,
  input  logic                  down_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            cnt_next
);

  logic                  main_valid_d;
  logic [DATA_WIDTH-1:0] main_data_d;

`ifdef PL_SKID_EN

  logic                  skid_valid;
  logic                  skid_valid_d;
  logic [DATA_WIDTH-1:0] skid_data;
  logic [DATA_WIDTH-1:0] skid_data_d;

  // Ready depends only on a flop, so no combinational path crosses the stage.
  assign ready = !skid_valid;

  // Next main/skid contents: the skid entry drains first, and it only fills
  // when a beat arrives while the main entry is stuck.
  always_comb begin
    main_valid_d = valid;
    main_data_d  = data;
    skid_valid_d = skid_valid;
    skid_data_d  = skid_data;
    if (!valid || down_ready) begin
      if (skid_valid) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = up_valid;
        if (up_valid) begin
          main_data_d = up_data;
        end
      end
    end else if (up_valid && ready) begin
      skid_valid_d = 1'b1;
      skid_data_d  = up_data;
    end
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VALUE;
      skid_valid_d = 1'b0;
      skid_data_d  = BUBBLE_VALUE;
    end
  end

  // Stage registers; reset restores the bubble in both entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      data       <= BUBBLE_VALUE;
      skid_valid <= 1'b0;
      skid_data  <= BUBBLE_VALUE;
    end else begin
      valid      <= main_valid_d;
      data       <= main_data_d;
      skid_valid <= skid_valid_d;
      skid_data  <= skid_data_d;
    end
  end

  assign cnt_next = {1'b0, main_valid_d} + {1'b0, skid_valid_d};

`else

  // The stage may load whenever it is empty or its beat leaves this cycle.
  assign ready = !valid || down_ready;

  // Next contents: load from upstream (a bubble just clears valid and keeps
  // the stale data), with flush taking priority over any load.
  always_comb begin
    main_valid_d = valid;
    main_data_d  = data;
    if (ready) begin
      main_valid_d = up_valid;
      if (up_valid) begin
        main_data_d = up_data;
      end
    end
    if (flush) begin
      main_valid_d = 1'b0;
      main_data_d  = BUBBLE_VALUE;
    end
  end

  // Stage register; reset restores the bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= BUBBLE_VALUE;
    end else begin
      valid <= main_valid_d;
      data  <= main_data_d;
    end
  end

  assign cnt_next = {1'b0, main_valid_d};

`endif

endmodule
`default_nettype wire

// File: rtl/pl_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : pl_stage_chain
// Purpose  : Parametrised chain of STAGES pipeline registers with
//            valid/ready flow control, per-stage flush into bubbles and a
//            registered count of valid entries.
// Config   : PL_SKID_EN - every stage gets a skid entry and a registered
//            ready, cutting the out_ready -> in_ready combinational path.
// Revision : 1.0 - initial release
// ============================================================================
module pl_stage_chain
  import pl_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           STAGES       = 1,
  parameter logic [DATA_WIDTH-1:0] BUBBLE_VALUE = DATA_WIDTH'(PL_NOP)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  input  logic [STAGES-1:0]              flush_mask,
  output logic [$clog2(2*STAGES+1)-1:0]  occupancy
);

  localparam int unsigned DEPTH = pl_clamp_stages(STAGES);
  localparam int unsigned OCC_W = $clog2(2*STAGES+1);

  logic [1:0]       stage_cnt [DEPTH];
  logic [OCC_W-1:0] occ_next;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic                  up_valid;
      logic [DATA_WIDTH-1:0] up_data;
      logic                  down_ready;
      logic                  ready;
      logic                  valid;
      logic [DATA_WIDTH-1:0] data;
      logic [1:0]            cnt_next;

      if (i == 0) begin : g_head
        assign up_valid = in_valid;
        assign up_data  = in_data;
      end else begin : g_link
        assign up_valid = g_stage[i-1].valid;
        assign up_data  = g_stage[i-1].data;
      end

      if (i == DEPTH - 1) begin : g_tail
        assign down_ready = out_ready;
      end else begin : g_mid
        assign down_ready = g_stage[i+1].ready;
      end

      pl_stage #(
        .DATA_WIDTH   (DATA_WIDTH),
        .BUBBLE_VALUE (BUBBLE_VALUE)
      ) u_stage (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush_mask[i]),
        .up_valid   (up_valid),
        .up_data    (up_data),
        .ready      (ready),
        .down_ready (down_ready),
        .valid      (valid),
        .data       (data),
        .cnt_next   (cnt_next)
      );

      assign stage_cnt[i] = cnt_next;
    end
  endgenerate

  assign in_ready  = g_stage[0].ready;
  assign out_valid = g_stage[DEPTH-1].valid;
  // Downstream never sees stale payload behind a bubble.
  assign out_data  = g_stage[DEPTH-1].valid ? g_stage[DEPTH-1].data : BUBBLE_VALUE;

  // Count of valid entries every stage will hold after the coming edge.
  always_comb begin
    occ_next = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occ_next = occ_next + OCC_W'(stage_cnt[k]);
    end
  end

  // Registered occupancy, so it matches the valid bits after each edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      occupancy <= occ_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pl_stage_chain.sv
`default_nettype none
// ============================================================================
// Module   : tb_pl_stage_chain
// Purpose  : Self-checking bench for pl_stage_chain (default build, no
//            PL_SKID_EN). A 3-stage instance is compared every cycle against
//            a slot-level reference model; a 2-stage instance covers the
//            stall/backpressure scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pl_stage_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // 3-stage instance
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic [2:0]  a_flush;
  logic [2:0]  a_occ;

  // 2-stage instance
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_flush;
  logic [2:0]  b_occ;

  pl_stage_chain #(.DATA_WIDTH(32), .STAGES(3), .BUBBLE_VALUE(32'h0)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush_mask(a_flush), .occupancy(a_occ)
  );

  pl_stage_chain #(.DATA_WIDTH(32), .STAGES(2), .BUBBLE_VALUE(32'h0)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush_mask(b_flush), .occupancy(b_occ)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Reference model of the 3-stage chain: one (valid, data) pair per slot,
  // slot 0 at the input side.
  bit          mv [3];
  logic [31:0] md [3];

  logic [31:0] cons_q[$];   // beats consumed at dut_a output
  int          cons_e[$];   // edge index of each consumption
  int          acc_e[$];    // edge index of each dut_a accept
  logic        last_in_ready;
  int          b_acc_n;
  logic [31:0] b_cons[$];
  logic        b_rdy_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Highest slot index that will take a new value this cycle: everything at
  // or below the topmost hole (or the whole chain when the output drains)
  // moves up by one. -1 means nothing moves.
  function automatic int m_top(input bit ordy);
    if (ordy) return 2;
    for (int k = 2; k >= 0; k--) begin
      if (!mv[k]) return k;
    end
    return -1;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int k = 0; k < 3; k++) n += int'(mv[k]);
    return n;
  endfunction

  function automatic void m_update(input bit r, input bit iv, input logic [31:0] id,
                                   input bit ordy, input logic [2:0] fm);
    int top;
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        mv[k] = 1'b0;
        md[k] = 32'h0;
      end
      return;
    end
    top = m_top(ordy);
    for (int k = top; k >= 1; k--) begin
      mv[k] = mv[k-1];
      md[k] = md[k-1];
    end
    if (top >= 0) begin
      mv[0] = iv;
      md[0] = id;
    end
    for (int k = 0; k < 3; k++) begin
      if (fm[k]) mv[k] = 1'b0;
    end
  endfunction

  // One clock cycle: drive dut_a, check it against the model before the
  // edge, log transfers on both instances, then advance the model.
  task automatic step(input bit r, input bit iv, input logic [31:0] id,
                      input bit ordy, input logic [2:0] fm);
    bit exp_ir;
    rst         = r;
    a_in_valid  = iv;
    a_in_data   = id;
    a_out_ready = ordy;
    a_flush     = fm;
    #1;
    exp_ir = (m_top(ordy) >= 0);
    chk("a_in_ready", {31'b0, a_in_ready}, {31'b0, exp_ir});
    chk("a_out_valid", {31'b0, a_out_valid}, {31'b0, mv[2]});
    chk("a_out_data", a_out_data, mv[2] ? md[2] : 32'h0);
    chk("a_occupancy", {29'b0, a_occ}, 32'(m_occ()));
    last_in_ready = a_in_ready;
    if (!r && a_out_valid && ordy) begin
      cons_q.push_back(a_out_data);
      cons_e.push_back(edge_n + 1);
    end
    if (!r && iv && exp_ir) acc_e.push_back(edge_n + 1);
    b_rdy_q.push_back(b_in_ready);
    if (!r && b_in_valid && b_in_ready) b_acc_n++;
    if (!r && b_out_valid && b_out_ready) b_cons.push_back(b_out_data);
    @(posedge clk);
    edge_n++;
    m_update(r, iv, id, ordy, fm);
    #1;
  endtask

  logic [31:0] beats [3];
  bit          r_iv, r_ordy, r_rst;
  logic [2:0]  r_fm;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = 32'h0; a_out_ready = 1'b1; a_flush = 3'b0;
    b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b1; b_flush = 2'b0;
    b_acc_n = 0;
    last_in_ready = 1'b0;
    m_update(1'b1, 1'b0, 32'h0, 1'b0, 3'b0);
    repeat (2) @(posedge clk);
    #1;

    // Reset with a beat offered: nothing may be captured.
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 3'b0);
    chk("reset_out_valid", {31'b0, a_out_valid}, 32'h0);
    chk("reset_out_data", a_out_data, 32'h0);
    chk("reset_occupancy", {29'b0, a_occ}, 32'h0);
    chk("reset_b_occupancy", {29'b0, b_occ}, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    chk("in_ready_after_reset", {31'b0, last_in_ready}, 32'h1);

    // Back-to-back stream 1..5 through 3 stages.
    cons_q.delete(); cons_e.delete(); acc_e.delete();
    for (int v = 1; v <= 5; v++) step(1'b0, 1'b1, 32'(v), 1'b1, 3'b0);
    repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    chk("stream_count", 32'(cons_q.size()), 32'd5);
    if (cons_q.size() == 5 && acc_e.size() == 5) begin
      chk("stream_latency", 32'(cons_e[0]), 32'(acc_e[0] + 3));
      for (int j = 0; j < 5; j++) begin
        chk("stream_data", cons_q[j], 32'(j + 1));
        chk("stream_gapless", 32'(cons_e[j]), 32'(cons_e[0] + j));
      end
    end

    // Two-stage backpressure: A, B fill it, C waits until out_ready returns.
    beats[0] = 32'hA0A0_0001; beats[1] = 32'hB0B0_0002; beats[2] = 32'hC0C0_0003;
    b_out_ready = 1'b0; b_acc_n = 0; b_rdy_q.delete(); b_cons.delete();
    for (int c = 0; c < 4; c++) begin
      b_in_valid = (b_acc_n < 3);
      b_in_data  = beats[(b_acc_n < 3) ? b_acc_n : 0];
      step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    end
    chk("b_in_ready_c0", {31'b0, b_rdy_q[0]}, 32'h1);
    chk("b_in_ready_c1", {31'b0, b_rdy_q[1]}, 32'h1);
    chk("b_in_ready_c2", {31'b0, b_rdy_q[2]}, 32'h0);
    chk("b_in_ready_c3", {31'b0, b_rdy_q[3]}, 32'h0);
    chk("b_occupancy_full", {29'b0, b_occ}, 32'h2);
    b_out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      b_in_valid = (b_acc_n < 3);
      b_in_data  = beats[(b_acc_n < 3) ? b_acc_n : 0];
      step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    end
    b_in_valid = 1'b0;
    chk("b_accepted", 32'(b_acc_n), 32'd3);
    chk("b_delivered", 32'(b_cons.size()), 32'd3);
    if (b_cons.size() == 3) begin
      for (int j = 0; j < 3; j++) chk("b_order", b_cons[j], beats[j]);
    end

    // Full 3-stage chain, flush stages 0 and 1: only the oldest beat leaves.
    step(1'b0, 1'b1, 32'd10, 1'b0, 3'b0);
    step(1'b0, 1'b1, 32'd11, 1'b0, 3'b0);
    step(1'b0, 1'b1, 32'd12, 1'b0, 3'b0);
    chk("full_occupancy", {29'b0, a_occ}, 32'h3);
    step(1'b0, 1'b0, 32'h0, 1'b0, 3'b011);
    chk("flush_occupancy", {29'b0, a_occ}, 32'h1);
    cons_q.delete();
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    chk("flush_survivors", 32'(cons_q.size()), 32'd1);
    if (cons_q.size() == 1) chk("flush_oldest", cons_q[0], 32'd10);
    chk("flush_bubble_data", a_out_data, 32'h0);

    // A beat accepted into a flushed input stage is discarded.
    cons_q.delete();
    step(1'b0, 1'b1, 32'h77, 1'b1, 3'b001);
    repeat (5) step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);
    chk("flushed_accept_gone", 32'(cons_q.size()), 32'd0);

    // Full chain with simultaneous consume and accept.
    step(1'b0, 1'b1, 32'd21, 1'b0, 3'b0);
    step(1'b0, 1'b1, 32'd22, 1'b0, 3'b0);
    step(1'b0, 1'b1, 32'd23, 1'b0, 3'b0);
    chk("full_in_ready_low", {31'b0, a_in_ready}, 32'h0);
    cons_q.delete();
    step(1'b0, 1'b1, 32'd24, 1'b1, 3'b0);
    chk("swap_in_ready", {31'b0, last_in_ready}, 32'h1);
    chk("swap_occupancy", {29'b0, a_occ}, 32'h3);
    if (cons_q.size() == 1) chk("swap_consumed", cons_q[0], 32'd21);
    else chk("swap_consumed_count", 32'(cons_q.size()), 32'd1);

    // Mid-stream reset discards everything in flight.
    step(1'b1, 1'b0, 32'h0, 1'b0, 3'b0);
    chk("midreset_occupancy", {29'b0, a_occ}, 32'h0);

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 400; c++) begin
      r_rst  = ($urandom_range(0, 99) == 0);
      r_iv   = ($urandom_range(0, 9) < 7);
      r_ordy = ($urandom_range(0, 9) < 7);
      r_fm   = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b0;
      step(r_rst, r_iv, $urandom, r_ordy, r_fm);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 3'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
